// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, memory-bus and fill-return signals of the shared-memory arbiter.
//   i_req/i_addr                     I-side block fill request pulse and byte address
//   d_req/d_wr/d_addr/d_wdata        D-side request pulse, write flag, byte address, write data
//   mem_en/mem_wr/mem_addr/mem_wdata memory access strobe, write strobe, address, write data
//   mem_rdata                        memory read data, fixed latency after a read issue
//   fill_valid/fill_owner/fill_word/fill_data  returned fill word, owner (1 = D), index, data
//   i_done/d_done                    one-cycle completion pulses
//   stall_if/stall_mem               per-side stall, high while pending or in service
//   modport master: arbiter view; modport slave: caches + memory view.
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        fill_valid;
    logic        fill_owner;
    logic [3:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        stall_if;
    logic        stall_mem;
    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_owner, fill_word,
               fill_data, i_done, d_done, stall_if, stall_mem
    );
    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_owner, fill_word,
               fill_data, i_done, d_done, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency pipelined memory between I-cache fills and D-cache fills/writes.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_arbiter_if.master: requests, memory bus, fill returns, done pulses, stalls
//   Optional: define MEM_ARB_ROUND_ROBIN_EN to break I/D ties in favour of the side not served last
//   (default: D-side fixed priority).
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master bus
);
    localparam int WB  = $clog2(BLOCK_WORDS);
    localparam int TOT = BLOCK_WORDS + MEM_LATENCY;
    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;
    state_t        state, next;
    logic [4:0]    cnt;
    logic          pend_i, pend_d, d_wr_q;
    logic [15:WB+1] i_blk;
    logic [15:0]   d_addr_q, d_wdata_q;
    logic          in_i, in_d, i_acc, d_acc, fill, issue, ret, last, pick_d;
    assign in_i  = state == I_FILL;
    assign in_d  = state == D_FILL || state == D_WRITE;
    assign i_acc = bus.i_req && !pend_i && !in_i;
    assign d_acc = bus.d_req && !pend_d && !in_d;
    // cnt counts cycles since entering a fill state: issues in 0..BW-1, returns in LAT..BW+LAT-1
    assign fill  = state == I_FILL || state == D_FILL;
    assign issue = fill && cnt < 5'(BLOCK_WORDS);
    assign ret   = fill && cnt >= 5'(MEM_LATENCY);
    assign last  = fill && cnt == 5'(TOT - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = pend_d && (!pend_i || !last_d);
`else
    assign pick_d = pend_d;
`endif
    always_comb begin
        next = state;
        if (state == IDLE)
            next = pick_d ? (d_wr_q ? D_WRITE : D_FILL) : pend_i ? I_FILL : IDLE;
        else if (state == D_WRITE || last)
            next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_i    <= 1'b0;
            pend_d    <= 1'b0;
            d_wr_q    <= 1'b0;
            i_blk     <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state  <= next;
            cnt    <= (state == IDLE || next == IDLE) ? '0 : cnt + 5'd1;
            pend_i <= i_acc || (pend_i && next != I_FILL);
            pend_d <= d_acc || (pend_d && next != D_FILL && next != D_WRITE);
            if (i_acc)
                i_blk <= bus.i_addr[15:WB+1];
            if (d_acc) begin
                d_addr_q  <= bus.d_addr;
                d_wr_q    <= bus.d_wr;
                d_wdata_q <= bus.d_wdata;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (state == IDLE && next != IDLE)
                last_d <= next != I_FILL;
`endif
        end
    end
    assign bus.mem_en     = issue || state == D_WRITE;
    assign bus.mem_wr     = state == D_WRITE;
    assign bus.mem_addr   = issue ? {(state == D_FILL ? d_addr_q[15:WB+1] : i_blk), cnt[WB-1:0], 1'b0}
                          : state == D_WRITE ? d_addr_q : '0;
    assign bus.mem_wdata  = state == D_WRITE ? d_wdata_q : '0;
    assign bus.fill_valid = ret;
    assign bus.fill_owner = ret && state == D_FILL;
    assign bus.fill_word  = ret ? 4'(cnt - 5'(MEM_LATENCY)) : '0;
    assign bus.fill_data  = ret ? bus.mem_rdata : '0;
    assign bus.i_done     = last && in_i;
    assign bus.d_done     = (last && state == D_FILL) || state == D_WRITE;
    assign bus.stall_if   = pend_i || in_i;
    assign bus.stall_mem  = pend_d || in_d;
endmodule
